step_clock_gen: RTL and testbench
=================================

Name: step_clock_gen

Overview:
- Generates the CPU stepping clock for the multicycle core. It sits directly upstream of the datapath/controller clock input.
- Turns a raw push-button or a free-running divider into clean, width-controlled cpu_clk pulses.
- Integrates synchronisation, debounce, single-step/run mode selection and a step counter for the debug display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles before the debounced button level changes (min 2)
RUN_DIV, 25000000, clk cycles between run-mode triggers (min 2)
HIGH_CYCLES, 8, clk cycles cpu_clk stays high per step (min 1)
LOW_CYCLES, 8, guard clk cycles cpu_clk stays low before the next trigger is accepted (min 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
btn  input  1  raw push-button, asynchronous to clk
run_en  input  1  raw mode switch, asynchronous: 1 = free-run, 0 = single-step
halt  input  1  synchronous to clk; blocks new triggers while high
cpu_clk  output  1  registered stepping clock to the CPU
step_pulse  output  1  one-clk-cycle strobe, coincident with the cpu_clk rising edge
busy  output  1  high while a pulse or its guard interval is in progress
step_count  output  16  number of cpu_clk pulses issued since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all flops clear, with outputs cpu_clk=0, step_pulse=0, busy=0, step_count=0.
  - Internal state clears as well: sync flops, debounced level, debounce counter, run divider and FSM state (IDLE).
  - Reset during HIGH drops cpu_clk immediately. No partial pulse resumes after release.
- Synchronisers: btn and run_en each pass through a 2-flop synchroniser, giving btn_s and run_s.
- Debounce:
  - If btn_s != db_level, db_cnt increments. On the DEBOUNCE_CYCLES-th consecutive mismatching edge, db_level <= btn_s and db_cnt <= 0.
  - Any cycle with btn_s == db_level clears db_cnt.
  - Glitches shorter than DEBOUNCE_CYCLES never change db_level.
- Edge detect: db_prev is db_level delayed one cycle. btn_rise = db_level & ~db_prev.
  - Only rising edges trigger. Release produces nothing.
- Run divider:
  - While run_s=1, div_cnt counts 0..RUN_DIV-1 and wraps. run_tick is asserted in the cycle div_cnt==RUN_DIV-1.
  - While run_s=0, div_cnt is held at 0.
- Trigger: trig = IDLE & ~halt & ((~run_s & btn_rise) | (run_s & run_tick)).
  - Triggers outside IDLE, or while halt=1, are dropped, not queued.
  - In run mode, button edges are ignored.
- FSM states: IDLE, HIGH, GUARD.
  - IDLE --trig--> HIGH. On this edge: cpu_clk <= 1, step_pulse <= 1 (one cycle), step_count <= step_count+1 (wraps 0xFFFF -> 0x0000).
  - HIGH: cpu_clk stays 1 for exactly HIGH_CYCLES clk cycles, then cpu_clk <= 0 and the FSM moves to GUARD.
  - GUARD: cpu_clk stays 0 for exactly LOW_CYCLES cycles, then the FSM returns to IDLE.
  - busy = (state != IDLE), registered together with the state.
- Mode change or halt assertion mid-pulse does not truncate the pulse. HIGH and GUARD always complete.
- Latency, single-step: btn rises between edges and is held. cpu_clk rises on the (DEBOUNCE_CYCLES+3)-th rising clk edge after the btn change: 2 for sync, DEBOUNCE_CYCLES for debounce, 1 for edge/trigger register.
- Minimum trigger spacing is HIGH_CYCLES+LOW_CYCLES cycles. For run mode, RUN_DIV should exceed this; shorter RUN_DIV causes dropped ticks, which is the specified behaviour.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=32, HIGH_CYCLES=3, LOW_CYCLES=2.)
1. Single step: run_en=0, btn 0->1 held 20 cycles -> cpu_clk rises on the 7th edge, high exactly 3 cycles, step_pulse 1 cycle, step_count=1, busy high 5 cycles. Releasing btn gives no second pulse.
2. Bounce: btn toggles with 3-cycle high / 2-cycle low periods for 30 cycles, then is held 1 -> exactly one cpu_clk pulse, step_count=1.
3. Run mode: run_en=1 for 200 cycles after sync -> a pulse every 32 cycles, step_count=6 (±1 per synchroniser alignment, checked against the first-tick edge). Button presses during the run produce no extra pulses.
4. Halt and drop: run mode with halt=1 across one run_tick -> that tick is dropped, step_count unchanged. A btn_rise arriving while busy=1 in step mode is dropped.
5. Async reset: rst asserted at the 2nd cycle of HIGH -> cpu_clk, busy and step_count go to 0 before the next clk edge, and the FSM is in IDLE after release.
6. Wrap: force step_count=0xFFFF (or issue 65536 steps with small parameters) -> the next pulse gives step_count=0x0000.

Source files
------------

// File: rtl/step_clock_gen.sv
// step_clock_gen: turns a bouncy push-button (single-step mode) or a free-running
// divider (run mode) into clean, width-controlled cpu_clk pulses for the
// multicycle core, and counts the pulses issued for the debug display.
module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int HIGH_CYCLES     = 8,
    parameter int LOW_CYCLES      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic        run_en,
    input  logic        halt,
    output logic        cpu_clk,
    output logic        step_pulse,
    output logic        busy,
    output logic [15:0] step_count
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [PH_W-1:0]  HI_LAST  = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0]  LO_LAST  = PH_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Front end: synchronisers, debouncer, edge detector, run divider
    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q,    btn_s_d;
    logic             run_meta_q, run_meta_d;
    logic             run_s_q,    run_s_d;
    logic             db_level_q, db_level_d;
    logic             db_prev_q,  db_prev_d;
    logic [DB_W-1:0]  db_cnt_q,   db_cnt_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic             btn_rise;
    logic             run_tick;

    // Pulse generator
    state_t           state_q,      state_d;
    logic [PH_W-1:0]  ph_cnt_q,     ph_cnt_d;
    logic             cpu_clk_q,    cpu_clk_d;
    logic             step_pulse_q, step_pulse_d;
    logic             busy_q,       busy_d;
    logic [15:0]      step_count_q, step_count_d;
    logic             trig;

    // State register for every flop in the block; reset clears everything at once
    // NOTE: sequential state uses non-blocking assignments so all flops sample the
    // pre-edge values, exactly like the hardware they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            run_meta_q   <= 1'b0;
            run_s_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            div_cnt_q    <= '0;
            state_q      <= IDLE;
            ph_cnt_q     <= '0;
            cpu_clk_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_meta_q   <= btn_meta_d;
            btn_s_q      <= btn_s_d;
            run_meta_q   <= run_meta_d;
            run_s_q      <= run_s_d;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_prev_d;
            db_cnt_q     <= db_cnt_d;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            ph_cnt_q     <= ph_cnt_d;
            cpu_clk_q    <= cpu_clk_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
        end
    end

    // Synchronise raw inputs, debounce the button, detect its rising edge, divide for run mode
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        btn_meta_d = btn;
        btn_s_d    = btn_meta_q;
        run_meta_d = run_en;
        run_s_d    = run_meta_q;
        db_level_d = db_level_q;
        db_prev_d  = db_level_q;
        db_cnt_d   = '0;
        div_cnt_d  = '0;
        run_tick   = 1'b0;

        // The level only follows btn_s after a full run of mismatching samples
        if (btn_s_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Divider is parked at zero outside run mode so each run starts with a full period
        if (run_s_q) begin
            if (div_cnt_q == DIV_LAST) begin
                run_tick = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        btn_rise = db_level_q & ~db_prev_q;
    end

    // Pulse FSM: accept a trigger only in IDLE, then run HIGH and GUARD to completion
    always_comb begin
        state_d      = state_q;
        ph_cnt_d     = ph_cnt_q;
        cpu_clk_d    = cpu_clk_q;
        step_pulse_d = 1'b0;
        step_count_d = step_count_q;

        // Triggers outside IDLE or under halt are dropped, never queued
        trig = (state_q == IDLE) && !halt && (run_s_q ? run_tick : btn_rise);

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d      = HIGH;
                    ph_cnt_d     = '0;
                    cpu_clk_d    = 1'b1;
                    step_pulse_d = 1'b1;
                    step_count_d = step_count_q + 16'd1;
                end
            end
            HIGH: begin
                if (ph_cnt_q == HI_LAST) begin
                    state_d   = GUARD;
                    ph_cnt_d  = '0;
                    cpu_clk_d = 1'b0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            GUARD: begin
                if (ph_cnt_q == LO_LAST) begin
                    state_d  = IDLE;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                ph_cnt_d  = '0;
                cpu_clk_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cpu_clk    = cpu_clk_q;
    assign step_pulse = step_pulse_q;
    assign busy       = busy_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen. A timestamp-based reference model
// predicts each pulse; a monitor compares the DUT against it every cycle.
module tb_step_clock_gen;

    localparam int D    = 4;
    localparam int RDIV = 32;
    localparam int HC   = 3;
    localparam int LC   = 2;
    localparam int MAXK = 65536;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        btn    = 1'b0;
    logic        run_en = 1'b0;
    logic        halt   = 1'b0;
    logic        cpu_clk;
    logic        step_pulse;
    logic        busy;
    logic [15:0] step_count;

    step_clock_gen #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV        (RDIV),
        .HIGH_CYCLES    (HC),
        .LOW_CYCLES     (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .run_en    (run_en),
        .halt      (halt),
        .cpu_clk   (cpu_clk),
        .step_pulse(step_pulse),
        .busy      (busy),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: k counts rising edges since reset release
    int          k       = 0;
    int          run_len = 0;
    int          last_e  = -1000;
    bit          b_h   [MAXK];
    bit          r_h   [MAXK];
    bit          lvl_h [MAXK];
    logic [15:0] m_count = 16'd0;
    bit          m_cpu   = 1'b0;
    bit          m_busy  = 1'b0;
    bit          force_wrap = 1'b0;

    // Observations gathered by the monitor
    int pulses      = 0;
    int obs_k       = -1;
    int busy_cycles = 0;
    int hi_cycles   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic bit hb(input int j);
        return (j < 1) ? 1'b0 : b_h[j];
    endfunction

    function automatic bit hr(input int j);
        return (j < 1) ? 1'b0 : r_h[j];
    endfunction

    function automatic bit lv(input int j);
        return (j < 1) ? 1'b0 : lvl_h[j];
    endfunction

    // Reference model. btn/run_en seen by the logic at edge j are the raw values
    // from edge j-2; the debounced level flips once D consecutive synced samples
    // disagree with it; a run tick falls on every RDIV-th edge of continuous run;
    // a trigger needs the generator idle, i.e. more than HC+LC edges past the last one.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k        = 0;
                run_len  = 0;
                last_e   = -1000;
                m_count  = 16'd0;
                m_cpu    = 1'b0;
                m_busy   = 1'b0;
                lvl_h[0] = 1'b0;
                exp_q.delete();
            end else begin
                bit   lvl, flip, rise, run_s, tick, idle;
                exp_t e;
                k++;
                if (k >= MAXK) begin
                    $display("FAIL model_range: edge count %0d exceeds history", k);
                    $fatal(1, "model history exhausted");
                end
                b_h[k] = btn;
                r_h[k] = run_en;
                lvl  = lv(k - 1);
                flip = 1'b1;
                for (int j = k - D + 1; j <= k; j++) begin
                    if (hb(j - 2) == lvl) flip = 1'b0;
                end
                lvl_h[k] = flip ? !lvl : lvl;
                rise    = lv(k - 1) && !lv(k - 2);
                run_s   = hr(k - 2);
                run_len = run_s ? run_len + 1 : 0;
                tick    = run_s && ((run_len % RDIV) == 0);
                idle    = (k > last_e + HC + LC);
                if (force_wrap) m_count = 16'hFFFF;
                if (idle && !halt && (run_s ? tick : rise)) begin
                    last_e  = k;
                    m_count = m_count + 16'd1;
                    e.k     = k;
                    e.count = m_count;
                    exp_q.push_back(e);
                end
                m_cpu  = (k >= last_e) && (k < last_e + HC);
                m_busy = (k >= last_e) && (k < last_e + HC + LC);
            end
        end
    end

    // Monitor: compares outputs on the falling edge and retires expected pulses
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            check("cpu_clk", cpu_clk, m_cpu);
            check("busy", busy, m_busy);
            check("step_count", step_count, m_count);
            if (busy === 1'b1) busy_cycles++;
            if (cpu_clk === 1'b1) hi_cycles++;
            if (step_pulse === 1'b1) begin
                pulses++;
                obs_k = k;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_pulse: step_pulse=1 at edge %0d, none expected", k);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_edge", k, e.k);
                    check("pulse_count", step_count, e.count);
                end
            end else if (exp_q.size() > 0 && exp_q[0].k <= k) begin
                e = exp_q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL missed_pulse: step_pulse=0 at edge %0d, pulse expected at edge %0d", k, e.k);
            end
        end
    end

    // Stimulus acts just after a falling edge, well away from the active edge
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int p0, k0, b0, h0, d, w;

        // Reset state
        cycles(2);
        check("rst_cpu_clk", cpu_clk, 1'b0);
        check("rst_step_pulse", step_pulse, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_step_count", step_count, 16'd0);
        rst = 1'b0;
        cycles(5);

        // 1: single step with latency, width and busy length
        p0 = pulses; b0 = busy_cycles; h0 = hi_cycles;
        k0 = k;
        btn = 1'b1;
        cycles(20);
        btn = 1'b0;
        cycles(15);
        check("t1_latency", obs_k - k0, D + 3);
        check("t1_pulses", pulses - p0, 1);
        check("t1_high_cycles", hi_cycles - h0, HC);
        check("t1_busy_cycles", busy_cycles - b0, HC + LC);
        check("t1_count", step_count, 16'd1);

        // 2: bouncing button, glitches shorter than the debounce window
        p0 = pulses;
        repeat (6) begin
            btn = 1'b1; cycles(3);
            btn = 1'b0; cycles(2);
        end
        btn = 1'b1; cycles(20);
        btn = 1'b0; cycles(15);
        check("t2_pulses", pulses - p0, 1);
        check("t2_count", step_count, 16'd2);

        // 3: run mode for 200 cycles with button noise
        p0 = pulses;
        run_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            cycles(1);
        end
        btn = 1'b0;
        cycles(50);
        run_en = 1'b0;
        cycles(20);
        d = pulses - p0;
        check("t3_run_pulses_in_range", (d >= 5 && d <= 7), 1'b1);

        // 4a: halt held across a run tick drops it
        run_en = 1'b1;
        cycles(10);
        halt = 1'b1;
        p0 = pulses;
        cycles(40);
        check("t4_halt_pulses", pulses - p0, 0);
        halt = 1'b0;
        cycles(30);
        run_en = 1'b0;
        cycles(20);

        // 4b: a button rise landing while a run-tick pulse is busy is dropped
        p0 = pulses;
        run_en = 1'b1;
        cycles(29);
        btn = 1'b1;
        cycles(3);
        run_en = 1'b0;
        cycles(20);
        check("t4_busy_drop_pulses", pulses - p0, 1);
        btn = 1'b0;
        cycles(15);

        // 5: asynchronous reset during the second HIGH cycle
        p0 = pulses;
        btn = 1'b1;
        w = 0;
        while (pulses == p0 && w < 30) begin
            cycles(1);
            w++;
        end
        if (pulses == p0) begin
            n_vec++;
            n_miss++;
            $display("FAIL t5_wait: no pulse within %0d cycles", w);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_cpu_clk", cpu_clk, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_step_count", step_count, 16'd0);
        btn = 1'b0;
        cycles(3);
        rst = 1'b0;
        p0 = pulses;
        cycles(20);
        check("t5_no_resume", pulses - p0, 0);

        // 6: preload the counter to 0xFFFF, next pulse wraps it
        cycles(1);
        force dut.step_count_d = 16'hFFFF;
        force_wrap = 1'b1;
        @(posedge clk);
        #1;
        release dut.step_count_d;
        force_wrap = 1'b0;
        cycles(2);
        check("t6_preset", step_count, 16'hFFFF);
        btn = 1'b1; cycles(15);
        btn = 1'b0; cycles(15);
        check("t6_wrap", step_count, 16'h0000);

        // Random mix of button, mode and halt activity
        for (int i = 0; i < 60; i++) begin
            btn    = 1'($urandom_range(0, 1));
            run_en = ($urandom_range(0, 5) == 0);
            halt   = ($urandom_range(0, 4) == 0);
            cycles($urandom_range(1, 14));
        end
        btn = 1'b0; run_en = 1'b0; halt = 1'b0;
        cycles(30);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "time limit reached");
    end

endmodule
